registra_mortes: RTL and testbench
==================================

# registra_mortes

Night-phase death registrar for the PoliLobinho game core. It is the writer of the per-player death mask that the death counter consumes. It collects kill requests and doctor saves during the night. On end of night it commits the surviving kills into the `mortes` mask in one cycle, then announces each new death, one per handshake, lowest player index first. It sits between the night-action sequencer and the day-phase display and vote logic.

## Interface
- `N_JOGADORES`, default 5: number of players; legal range 2..7.
- `clock` in, 1 bit: system clock; all state changes on the rising edge.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `nova_partida` in, 1 bit: synchronous clear of all game state.
- `kill_valid` in, 1 bit: kill request strobe.
- `kill_id` in, 3 bits: target player index.
- `kill_ready` out, 1 bit: block accepts kill and save requests.
- `save_valid` in, 1 bit: doctor-save strobe.
- `save_id` in, 3 bits: saved player index.
- `fim_noite` in, 1 bit: end-of-night strobe; triggers the commit.
- `erro` out, 1 bit: one-cycle pulse when a request is rejected.
- `evt_valid` out, 1 bit: death announcement is valid.
- `evt_id` out, 3 bits: index of the player being announced.
- `evt_ready` in, 1 bit: consumer accepts the announcement.
- `dia_pronto` out, 1 bit: one-cycle pulse when all announcements are done.
- `mortes` out, `N_JOGADORES` bits: registered death mask; bit i set means player i is dead.
- `vivos` out, 3 bits: `N_JOGADORES` minus popcount(`mortes`).

## Operation
- Internal registers:
  - `pend`: pending-kill mask, `N_JOGADORES` bits.
  - `anun`: announce mask, `N_JOGADORES` bits.
  - State machine with states COLETA and ANUNCIA.
- COLETA state:
  - `kill_ready`=1.
  - A kill request is handled only when `kill_valid`=1 and `kill_ready`=1.
  - A valid kill (`kill_id` < N and player alive) sets `pend[kill_id]`.
  - Killing a player who is already pending is idempotent and raises no error.
  - A kill whose `kill_id` ≥ N, or whose target is already dead in `mortes`, is rejected. `pend` is unchanged and `erro` pulses.
  - A valid save (`save_id` < N) clears `pend[save_id]`. A save with `save_id` ≥ N is rejected and `erro` pulses. Saving a player who is not pending is a no-op.
  - Same-cycle kill and save on the same id: the save wins and the bit ends cleared.
  - `fim_noite`: requests presented in the same cycle are applied first, then the commit happens.
    - Commit: `mortes` |= pend', `anun` <= pend', `pend` <= 0, where pend' is `pend` after this cycle's requests.
    - If pend' is nonzero, go to ANUNCIA.
    - If pend' is zero, pulse `dia_pronto` next cycle and stay in COLETA.
- ANUNCIA state:
  - `kill_ready`=0. Kill, save and `fim_noite` inputs are ignored; ignored inputs do not raise `erro`.
  - `evt_valid`=1 and `evt_id` = lowest set index in `anun`.
  - On `evt_valid`&&`evt_ready`, clear that bit of `anun`.
  - If `anun` becomes empty, go to COLETA and pulse `dia_pronto`.
  - `evt_id` is stable while `evt_valid`=1 and `evt_ready`=0.
- `nova_partida`:
  - Highest priority below reset, in any state.
  - Clears `mortes`, `pend` and `anun`, and goes to COLETA.
  - All other inputs are ignored that cycle.
  - `erro`, `evt_valid` and `dia_pronto` are 0 in the following cycle.
- `vivos` is combinational from `mortes`. It is always in 0..N and never wraps.

## Timing
- Reset values:
  - State is COLETA; `mortes`, `pend` and `anun` are 0.
  - `kill_ready`=1, `erro`=0, `evt_valid`=0, `evt_id`=0, `dia_pronto`=0.
  - `vivos`=`N_JOGADORES`.
- All outputs are registered except `kill_ready`, `evt_valid`, `evt_id` and `vivos`, which are decoded from registered state.
- Request latency:
  - `pend` updates the edge after acceptance.
  - `erro` is high exactly one cycle, in the cycle after the offending request.
- Commit latency:
  - `mortes` updates on the `fim_noite` edge.
  - `evt_valid` rises in the next cycle.
- Announcement throughput: one event per cycle when `evt_ready` is held high.
- `dia_pronto` timing:
  - With k ≥ 1 deaths and continuous `evt_ready`, `dia_pronto` is high in cycle `fim_noite`+k+1.
  - When `dia_pronto` is high, `kill_ready` is already 1.
- Reset mid-announcement: all state is lost immediately and asynchronously; nothing resumes.

## Test plan
- Reset, then kill ids 1 and 3, then `fim_noite`, `evt_ready`=1:
  - `mortes`=5'b01010 and `vivos`=3.
  - Events are id 1 then id 3 on consecutive cycles, then `dia_pronto` pulses.
- Kill 2 and save 2 in the same cycle, then `fim_noite` → no events, `dia_pronto` one cycle later, `mortes` unchanged.
- After player 0 is dead, kill 0, then kill 6 → `erro` pulses once for each request, `pend`=0.
- Kill 4, `fim_noite`, `evt_ready`=0 for 5 cycles:
  - `evt_valid` held, `evt_id`=4, `kill_ready`=0.
  - A kill on id 1 during this time is ignored.
  - Raise `evt_ready` → `dia_pronto` pulses next cycle.
- Kill ids 0 to 3 and commit (`vivos`=1), then assert `nova_partida` mid-ANUNCIA → `mortes`=0, `vivos`=5, `evt_valid`=0 next cycle.
- Deassert `reset_n` asynchronously while `evt_valid`=1 → outputs return to their reset values with no clock edge required.

Source files
------------

// File: rtl/registra_mortes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | registra_mortes: night-phase death registrar, commits kills to the death   |
// | mask and announces each new death lowest index first. Rev 1.0              |
// +----------------------------------------------------------------------------+
module registra_mortes #(
    parameter int N_JOGADORES = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   nova_partida,
    input  logic                   kill_valid,
    input  logic [2:0]             kill_id,
    output logic                   kill_ready,
    input  logic                   save_valid,
    input  logic [2:0]             save_id,
    input  logic                   fim_noite,
    output logic                   erro,
    output logic                   evt_valid,
    output logic [2:0]             evt_id,
    input  logic                   evt_ready,
    output logic                   dia_pronto,
    output logic [N_JOGADORES-1:0] mortes,
    output logic [2:0]             vivos
);

    localparam logic [0:0]             S_COLETA  = 1'b0;
    localparam logic [0:0]             S_ANUNCIA = 1'b1;
    localparam logic [3:0]             c_N_EXT   = 4'(N_JOGADORES);
    localparam logic [2:0]             c_N3      = 3'(N_JOGADORES);
    localparam logic [N_JOGADORES-1:0] c_ONE     = {{(N_JOGADORES-1){1'b0}}, 1'b1};

    logic [0:0]             r_state;
    logic [N_JOGADORES-1:0] r_mortes;
    logic [N_JOGADORES-1:0] r_pend;
    logic [N_JOGADORES-1:0] r_anun;
    logic                   r_erro;
    logic                   r_dia;

    logic [N_JOGADORES-1:0] w_kill_mask;
    logic [N_JOGADORES-1:0] w_save_mask;
    logic                   w_kill_in_range;
    logic                   w_save_in_range;
    logic                   w_kill_ok;
    logic                   w_kill_bad;
    logic                   w_save_ok;
    logic                   w_save_bad;
    logic [N_JOGADORES-1:0] w_pend_next;
    logic [2:0]             w_evt_id;
    logic [N_JOGADORES-1:0] w_evt_mask;
    logic [N_JOGADORES-1:0] w_anun_next;
    logic [2:0]             w_count;

    // Out-of-range ids shift the one-hot mask off the top, giving an empty mask
    assign w_kill_mask     = c_ONE << kill_id;
    assign w_save_mask     = c_ONE << save_id;
    assign w_kill_in_range = {1'b0, kill_id} < c_N_EXT;
    assign w_save_in_range = {1'b0, save_id} < c_N_EXT;
    assign w_kill_ok       = kill_valid && w_kill_in_range && ((r_mortes & w_kill_mask) == '0);
    assign w_kill_bad      = kill_valid && !w_kill_ok;
    assign w_save_ok       = save_valid && w_save_in_range;
    assign w_save_bad      = save_valid && !w_save_in_range;
    assign w_pend_next     = (r_pend | (w_kill_ok ? w_kill_mask : '0))
                           & ~(w_save_ok ? w_save_mask : '0);

    always_comb begin
        w_evt_id = 3'd0;
        for (int i = N_JOGADORES - 1; i >= 0; i--) begin
            if (r_anun[i]) w_evt_id = 3'(i);
        end
    end

    assign w_evt_mask  = c_ONE << w_evt_id;
    assign w_anun_next = r_anun & ~w_evt_mask;

    always_comb begin
        w_count = 3'd0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            w_count = w_count + {2'b00, r_mortes[i]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_COLETA;
            r_mortes <= '0;
            r_pend   <= '0;
            r_anun   <= '0;
            r_erro   <= 1'b0;
            r_dia    <= 1'b0;
        end else begin
            r_erro <= 1'b0;
            r_dia  <= 1'b0;
            if (nova_partida) begin
                r_state  <= S_COLETA;
                r_mortes <= '0;
                r_pend   <= '0;
                r_anun   <= '0;
            end else if (r_state == S_COLETA) begin
                r_erro <= w_kill_bad || w_save_bad;
                if (fim_noite) begin
                    r_mortes <= r_mortes | w_pend_next;
                    r_anun   <= w_pend_next;
                    r_pend   <= '0;
                    if (w_pend_next != '0) r_state <= S_ANUNCIA;
                    else                   r_dia   <= 1'b1;
                end else begin
                    r_pend <= w_pend_next;
                end
            end else if (evt_ready) begin
                r_anun <= w_anun_next;
                if (w_anun_next == '0) begin
                    r_state <= S_COLETA;
                    r_dia   <= 1'b1;
                end
            end
        end
    end

    assign kill_ready = (r_state == S_COLETA);
    assign evt_valid  = (r_state == S_ANUNCIA);
    assign evt_id     = w_evt_id;
    assign erro       = r_erro;
    assign dia_pronto = r_dia;
    assign mortes     = r_mortes;
    assign vivos      = c_N3 - w_count;

endmodule
`default_nettype wire

// File: tb/tb_registra_mortes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_registra_mortes: directed and random checks against a queue-based model |
// | of the night/announcement rules. Rev 1.0                                   |
// +----------------------------------------------------------------------------+
module tb_registra_mortes;

    localparam int N = 5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         nova_partida, kill_valid, save_valid, fim_noite, evt_ready;
    logic [2:0]   kill_id, save_id;
    logic         kill_ready, erro, evt_valid, dia_pronto;
    logic [2:0]   evt_id, vivos;
    logic [N-1:0] mortes;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: dead/pending flags per player and a queue of pending announcements
    bit m_dead [N];
    bit m_pend [N];
    int m_q [$];
    bit m_anuncia;
    bit m_erro;
    bit m_dia;

    registra_mortes #(.N_JOGADORES(N)) dut (
        .clock(clock), .reset_n(reset_n), .nova_partida(nova_partida),
        .kill_valid(kill_valid), .kill_id(kill_id), .kill_ready(kill_ready),
        .save_valid(save_valid), .save_id(save_id), .fim_noite(fim_noite),
        .erro(erro), .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
        .dia_pronto(dia_pronto), .mortes(mortes), .vivos(vivos)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_dead[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_q.delete();
        m_anuncia = 1'b0;
        m_erro    = 1'b0;
        m_dia     = 1'b0;
    endtask

    task automatic model_step();
        int kid;
        int sid;
        kid    = int'(kill_id);
        sid    = int'(save_id);
        m_erro = 1'b0;
        m_dia  = 1'b0;
        if (nova_partida) begin
            model_reset();
        end else if (!m_anuncia) begin
            if (kill_valid) begin
                if (kid < N) begin
                    if (m_dead[kid]) m_erro = 1'b1;
                    else             m_pend[kid] = 1'b1;
                end else begin
                    m_erro = 1'b1;
                end
            end
            if (save_valid) begin
                if (sid < N) m_pend[sid] = 1'b0;
                else         m_erro = 1'b1;
            end
            if (fim_noite) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i]) begin
                        m_dead[i] = 1'b1;
                        m_q.push_back(i);
                        m_pend[i] = 1'b0;
                    end
                end
                if (m_q.size() > 0) m_anuncia = 1'b1;
                else                m_dia     = 1'b1;
            end
        end else if (evt_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_anuncia = 1'b0;
                m_dia     = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] e_m;
        int           n_dead;
        int           e_id;
        e_m    = '0;
        n_dead = 0;
        for (int i = 0; i < N; i++) begin
            e_m[i] = m_dead[i];
            n_dead += int'(m_dead[i]);
        end
        e_id = m_anuncia ? m_q[0] : 0;
        check({tag, "_kill_ready"}, {7'b0, kill_ready}, {7'b0, !m_anuncia});
        check({tag, "_evt_valid"},  {7'b0, evt_valid},  {7'b0, m_anuncia});
        check({tag, "_evt_id"},     {5'b0, evt_id},     8'(e_id));
        check({tag, "_erro"},       {7'b0, erro},       {7'b0, m_erro});
        check({tag, "_dia_pronto"}, {7'b0, dia_pronto}, {7'b0, m_dia});
        check({tag, "_mortes"},     {3'b0, mortes},     {3'b0, e_m});
        check({tag, "_vivos"},      {5'b0, vivos},      8'(N - n_dead));
    endtask

    task automatic drive(input logic kv, input logic [2:0] kid, input logic sv,
                         input logic [2:0] sid, input logic fim, input logic er,
                         input logic np);
        kill_valid   = kv;
        kill_id      = kid;
        save_valid   = sv;
        save_id      = sid;
        fim_noite    = fim;
        evt_ready    = er;
        nova_partida = np;
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Two kills committed, announced back to back
        drive(1, 1, 0, 0, 0, 1, 0); cycle("k1");
        drive(1, 3, 0, 0, 0, 1, 0); cycle("k3");
        drive(0, 0, 0, 0, 1, 1, 0); cycle("fim13");
        check("tp1_mortes", {3'b0, mortes}, 8'b0000_1010);
        check("tp1_vivos",  {5'b0, vivos},  8'd3);
        check("tp1_first",  {5'b0, evt_id}, 8'd1);
        drive(0, 0, 0, 0, 0, 1, 0); cycle("ev3");
        check("tp1_second", {5'b0, evt_id}, 8'd3);
        cycle("dia13");
        check("tp1_dia", {7'b0, dia_pronto}, 8'd1);

        // Same-cycle kill and save: save wins
        drive(1, 2, 1, 2, 0, 1, 0); cycle("ks2");
        drive(0, 0, 0, 0, 1, 1, 0); cycle("fim_empty");
        check("tp2_dia", {7'b0, dia_pronto}, 8'd1);
        check("tp2_mortes", {3'b0, mortes}, 8'b0000_1010);

        // Dead target and out-of-range target are rejected
        drive(1, 0, 0, 0, 1, 1, 0); cycle("k0fim");
        drive(0, 0, 0, 0, 0, 1, 0); cycle("ev0");
        drive(1, 0, 0, 0, 0, 1, 0); cycle("k0dead");
        check("tp3_erro_dead", {7'b0, erro}, 8'd1);
        drive(1, 6, 0, 0, 0, 1, 0); cycle("k6");
        check("tp3_erro_range", {7'b0, erro}, 8'd1);
        drive(0, 0, 1, 7, 0, 1, 0); cycle("s7");
        drive(0, 0, 0, 0, 1, 1, 0); cycle("fim_pend0");

        // Back-pressure holds the announcement; requests meanwhile are ignored
        drive(1, 4, 0, 0, 1, 0, 0); cycle("k4fim");
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 6, 1, 0, 0); cycle("hold");
            check("tp4_id", {5'b0, evt_id}, 8'd4);
        end
        drive(0, 0, 0, 0, 0, 1, 0); cycle("ev4");
        check("tp4_dia", {7'b0, dia_pronto}, 8'd1);

        // New game mid-announcement
        drive(0, 0, 0, 0, 0, 0, 1); cycle("np0");
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'(i), 0, 0, 0, 0, 0); cycle("k03");
        end
        drive(0, 0, 0, 0, 1, 0, 0); cycle("fim03");
        check("tp5_vivos1", {5'b0, vivos}, 8'd1);
        drive(0, 0, 0, 0, 0, 1, 1); cycle("np1");
        check("tp5_mortes", {3'b0, mortes}, 8'd0);
        check("tp5_vivos5", {5'b0, vivos}, 8'd5);

        // Asynchronous reset while announcing
        drive(1, 2, 0, 0, 1, 0, 0); cycle("k2fim");
        drive(0, 0, 0, 0, 0, 0, 0); cycle("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 63) == 0));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
